// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_pkg;

    localparam int XLEN  = 32;
    localparam int BE_W  = 4;
    localparam int CNT_W = 4;

    // Data returned for any read that falls outside the legal window.
    localparam logic [XLEN-1:0] ILLEGAL_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM with byte-write enables and a registered read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [BE_W-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            re_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    // Byte-masked write into storage.
    // NOTE: the storage array has no reset; clearing a RAM is neither needed nor synthesizable as block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; holds its value until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, inserts wait states,
// answers with a one-cycle mem_rdy pulse and flags illegal accesses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter int unsigned     WAIT_CYCLES = 1,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            sys_rst,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [BE_W-1:0] mem_be,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_rdy,
    output logic            busy,
    output logic            err
);

    localparam int unsigned   AW   = $clog2(DEPTH_WORDS);
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [BE_W-1:0]  be_q;
    logic [XLEN-1:0]  adr_q;
    logic [XLEN-1:0]  wdata_q;
    logic             rdy_q;
    logic             busy_q;
    logic             err_q;
    logic             rd_illegal_q;

    logic             from_idle;
    logic             enter_resp;
    logic             acc_we;
    logic [BE_W-1:0]  acc_be;
    logic [XLEN-1:0]  acc_adr;
    logic [XLEN-1:0]  acc_wdata;
    logic [XLEN:0]    acc_diff;
    logic             acc_legal;
    logic             arr_we;
    logic             arr_re;
    logic [XLEN-1:0]  arr_rdata;

    // With zero wait states the array is accessed on the acceptance edge itself,
    // so the live inputs are used from IDLE and the latched copies otherwise.
    assign from_idle  = (state_q == IDLE);
    assign acc_we     = from_idle ? mem_we    : we_q;
    assign acc_be     = from_idle ? mem_be    : be_q;
    assign acc_adr    = from_idle ? mem_adr   : adr_q;
    assign acc_wdata  = from_idle ? mem_wdata : wdata_q;

    // An address below BASE_ADDR wraps to a huge 33-bit difference and fails the span test.
    assign acc_diff   = {1'b0, acc_adr} - {1'b0, BASE_ADDR};
    assign acc_legal  = (acc_adr[1:0] == 2'b00) && (acc_diff < SPAN);
    assign enter_resp = (state_d == RESP);
    assign arr_we     = enter_resp && acc_we && acc_legal;
    assign arr_re     = enter_resp && !acc_we && acc_legal;

    // Next-state and wait counter; abort takes priority over completion.
    // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (!mem_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, request latches, registered status outputs and sticky error.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            adr_q        <= '0;
            wdata_q      <= '0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= enter_resp;
            busy_q  <= (state_d != IDLE);
            if (from_idle && mem_req) begin
                we_q    <= mem_we;
                be_q    <= mem_be;
                adr_q   <= mem_adr;
                wdata_q <= mem_wdata;
            end
            if (enter_resp && !acc_legal) begin
                err_q <= 1'b1;
            end
            if (enter_resp && !acc_we) begin
                rd_illegal_q <= !acc_legal;
            end
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .rst     (sys_rst),
        .we_i    (arr_we),
        .be_i    (acc_be),
        .addr_i  (acc_diff[AW+1:2]),
        .wdata_i (acc_wdata),
        .re_i    (arr_re),
        .rdata_o (arr_rdata)
    );

    assign mem_rdata = rd_illegal_q ? ILLEGAL_RDATA : arr_rdata;
    assign mem_rdy   = rdy_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders with different wait-state/window settings.
//   d=0: WAIT_CYCLES=1, 1024 words at 0x0
//   d=1: WAIT_CYCLES=3, 64 words at 0x40
//   d=2: WAIT_CYCLES=0, 16 words at 0x0
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        req   [3];
    logic        we    [3];
    logic [3:0]  be    [3];
    logic [31:0] adr   [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic        busy  [3];
    logic        err   [3];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk(clk), .sys_rst(sys_rst), .mem_req(req[0]), .mem_we(we[0]), .mem_be(be[0]),
        .mem_adr(adr[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_rdy(rdy[0]),
        .busy(busy[0]), .err(err[0]));

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0040)) u_dut1 (
        .clk(clk), .sys_rst(sys_rst), .mem_req(req[1]), .mem_we(we[1]), .mem_be(be[1]),
        .mem_adr(adr[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_rdy(rdy[1]),
        .busy(busy[1]), .err(err[1]));

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut2 (
        .clk(clk), .sys_rst(sys_rst), .mem_req(req[2]), .mem_we(we[2]), .mem_be(be[2]),
        .mem_adr(adr[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_rdy(rdy[2]),
        .busy(busy[2]), .err(err[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete access: expected result is queued at drive time, popped at mem_rdy.
    task automatic access(input int d, input int lat, input bit w, input logic [3:0] be_v,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_e, input string tag);
        int   n;
        exp_t e;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; be[d] = be_v; adr[d] = a; wdata[d] = wd;
        sb.push_back('{exp_rd, exp_e});
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n++;
            if (rdy[d]) break;
            // Inputs after acceptance must not matter.
            we[d] = 1'($urandom_range(0, 1)); be[d] = 4'($urandom);
            adr[d] = $urandom; wdata[d] = $urandom;
        end
        check($sformatf("%s latency", tag), 32'(n), 32'(lat));
        e = sb.pop_front();
        check($sformatf("%s rdata", tag), rdata[d], e.rdata);
        check($sformatf("%s err", tag), 32'(err[d]), 32'(e.err));
        check($sformatf("%s busy_resp", tag), 32'(busy[d]), 32'd1);
        req[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s rdy_drop", tag), 32'(rdy[d]), 32'd0);
        check($sformatf("%s busy_idle", tag), 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit   saw;
        int   k;

        sys_rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0; adr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset rdy%0d", d), 32'(rdy[d]), 32'd0);
            check($sformatf("reset busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset err%0d", d), 32'(err[d]), 32'd0);
            check($sformatf("reset rdata%0d", d), rdata[d], 32'd0);
        end

        // Table for d=0; expected rdata of a write is the value held from the previous read.
        tbl[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'hCAFE_F00D, 1'b0};
        tbl[4]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'hCAFE_F00D, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
        tbl[6]  = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h55AA_55AA, 32'h11BB_33DD, 1'b0};
        tbl[7]  = '{1'b1, 4'h0, 32'h0000_0FFC, 32'hFFFF_FFFF, 32'h11BB_33DD, 1'b0};
        tbl[8]  = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         32'h55AA_55AA, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
        tbl[10] = '{1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b1};
        for (int i = 0; i < 13; i++) begin
            access(0, 2, tbl[i].we, tbl[i].be, tbl[i].adr, tbl[i].wdata,
                   tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("d0_vec%0d", i));
        end

        // d=1: abort, window boundaries, reset mid-wait.
        access(1, 4, 1'b1, 4'hF, 32'h40, 32'h0102_0304, 32'h0, 1'b0, "d1_wr40");
        access(1, 4, 1'b0, 4'h0, 32'h40, 32'h0,         32'h0102_0304, 1'b0, "d1_rd40");
        access(1, 4, 1'b1, 4'hF, 32'h44, 32'h1357_9BDF, 32'h0102_0304, 1'b0, "d1_wr44");

        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; adr[1] = 32'h40; wdata[1] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("abort busy_wait", 32'(busy[1]), 32'd1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            saw |= rdy[1];
        end
        check("abort no_rdy", 32'(saw), 32'd0);
        check("abort busy", 32'(busy[1]), 32'd0);
        check("abort rdata_held", rdata[1], 32'h0102_0304);
        access(1, 4, 1'b0, 4'h0, 32'h40,  32'h0, 32'h0102_0304, 1'b0, "d1_rd40_after_abort");
        access(1, 4, 1'b0, 4'h0, 32'h3C,  32'h0, 32'h0,         1'b1, "d1_rd_below_base");
        access(1, 4, 1'b0, 4'h0, 32'h140, 32'h0, 32'h0,         1'b1, "d1_rd_above_top");

        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; adr[1] = 32'h44; wdata[1] = 32'h7777_7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rstmid busy_before", 32'(busy[1]), 32'd1);
        sys_rst = 1'b1;
        #1;
        check("rstmid rdy", 32'(rdy[1]), 32'd0);
        check("rstmid busy", 32'(busy[1]), 32'd0);
        check("rstmid err", 32'(err[1]), 32'd0);
        @(posedge clk); #1;
        check("rstmid rdy_next", 32'(rdy[1]), 32'd0);
        check("rstmid busy_next", 32'(busy[1]), 32'd0);
        req[1] = 1'b0;
        @(negedge clk);
        sys_rst = 1'b0;
        access(1, 4, 1'b0, 4'h0, 32'h44, 32'h0, 32'h1357_9BDF, 1'b0, "d1_rd44_after_reset");
        access(1, 4, 1'b0, 4'h0, 32'h40, 32'h0, 32'h0102_0304, 1'b0, "d1_rd40_after_reset");

        // d=2: zero wait states, then back-to-back reads with mem_req held high.
        access(2, 1, 1'b1, 4'hF, 32'h0, 32'h0000_AAAA, 32'h0, 1'b0, "d2_wr0");
        access(2, 1, 1'b1, 4'hF, 32'h4, 32'h0000_BBBB, 32'h0, 1'b0, "d2_wr4");
        access(2, 1, 1'b1, 4'hF, 32'h8, 32'h0000_CCCC, 32'h0, 1'b0, "d2_wr8");

        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'h0; adr[2] = 32'h0;
        sb.push_back('{32'h0000_AAAA, 1'b0});
        sb.push_back('{32'h0000_BBBB, 1'b0});
        sb.push_back('{32'h0000_CCCC, 1'b0});
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b rdy_cycle%0d", i), 32'(rdy[2]), 32'((i % 2) == 0));
            if (rdy[2] && sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("b2b rdata%0d", k), rdata[2], e.rdata);
                k++;
                if (k == 3) req[2] = 1'b0;
                else        adr[2] = 32'(4 * k);
            end
        end
        req[2] = 1'b0;
        check("b2b all_done", 32'(sb.size()), 32'd0);
        sb.delete();

        access(2, 1, 1'b1, 4'hF, 32'h40, 32'hFFFF_FFFF, 32'h0000_CCCC, 1'b1, "d2_wr_oob");
        access(2, 1, 1'b0, 4'h0, 32'h0,  32'h0,         32'h0000_AAAA, 1'b1, "d2_rd0_unchanged");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle processor's unified instruction/data memory port. It accepts one read or write request at a time from the control unit. It inserts a configurable number of wait states and answers each accepted request with a single-cycle `mem_rdy` pulse. It owns the word-organised storage behind the port and flags illegal accesses without ever hanging the processor.

## Interface
- `DEPTH_WORDS`, 1024: storage size in 32-bit words; power of two.
- `WAIT_CYCLES`, 1: extra cycles between acceptance and `mem_rdy`; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `mem_req`  in  1  level request from the control unit; held until `mem_rdy` is seen.
- `mem_we`  in  1  1 = write, 0 = read; sampled at acceptance.
- `mem_be`  in  4  byte enables for writes; bit i selects `wdata[8i+7:8i]`.
- `mem_adr`  in  32  byte address; sampled at acceptance.
- `mem_wdata`  in  32  write data; sampled at acceptance.
- `mem_rdata`  out  32  read data; valid while `mem_rdy`=1 and held until the next read completes.
- `mem_rdy`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from acceptance through the `mem_rdy` cycle.
- `err`  out  1  sticky illegal-access flag.

## Operation
- States:
  - IDLE: accept when `mem_req`=1 and latch `we`, `be`, `adr`, `wdata`.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise: load `cnt`=WAIT_CYCLES and go to WAIT.
  - WAIT: decrement `cnt`. Go to RESP when `cnt`=1 at the edge. If `mem_req` is sampled low, go to IDLE (abort).
  - RESP: `mem_rdy`=1 for exactly one cycle, then unconditionally go to IDLE.
- Legal access: word-aligned (`adr[1:0]`=0) and `BASE_ADDR` ≤ adr < `BASE_ADDR`+4·DEPTH_WORDS. Index = (adr−BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- Write commit: on the edge entering RESP, legal accesses only. Only enabled bytes change. `mem_be`=0 completes without changing storage.
- Read: the array is read on the edge entering RESP. `mem_rdata` is registered and valid in the RESP cycle.
- Illegal access:
  - Completes normally with `mem_rdy`.
  - Read returns 32'h0000_0000.
  - Write is suppressed.
  - `err` sets on the edge entering RESP.
- Abort: `mem_req` low in WAIT returns to IDLE with no write, no `mem_rdy`, and `mem_rdata` unchanged.
- Input changes after acceptance are ignored; latched values govern the access.
- Back-to-back: `mem_req` high in the IDLE cycle after RESP is a new request. There is no forced gap beyond RESP→IDLE.

## Timing
- Reset values: state IDLE, `mem_rdy`=0, `busy`=0, `err`=0, `mem_rdata`=0, `cnt`=0. Storage is not cleared.
- Latency: request accepted at edge E0 → `mem_rdy` high in the cycle after edge E0+WAIT_CYCLES. Minimum 1 cycle when WAIT_CYCLES=0.
- Issue rate:
  - WAIT_CYCLES=0: one access per 2 cycles (IDLE, RESP).
  - General case: one access per WAIT_CYCLES+2 cycles.
- Reset mid-operation: immediate return to IDLE. A pending write is not committed and no `mem_rdy` is issued. `err` clears.
- `busy` is registered and matches state ≠ IDLE.

## Structure
- Package `mem_pkg`:
  - State encoding `mem_state_t` (IDLE, WAIT, RESP).
  - `ILLEGAL_RDATA` constant (32'h0).
  - Width constants `XLEN`=32 and `BE_W`=4.
- Sub-module `mem_array`: single-port synchronous RAM with byte-write enables and a registered read port, parameterised by DEPTH_WORDS. The FSM, latches, counter and legality check live in `mem_responder`.

## Test plan
- Write then read, WAIT_CYCLES=1:
  - Write 32'hCAFE_F00D to 0x10 with be=4'hF → `mem_rdy` 2 cycles after acceptance.
  - Read 0x10 → `mem_rdata`=32'hCAFE_F00D with `mem_rdy`, and `err`=0.
- Byte enables: word 0x20 = 32'h1122_3344, then write 32'hAABB_CCDD with be=4'b0101 → read 0x20 returns 32'h11BB_33DD.
- Illegal accesses:
  - Read 0x13 (misaligned) → `mem_rdy` pulses, `mem_rdata`=0, `err`=1 and stays 1.
  - Write to BASE+4·DEPTH_WORDS → storage unchanged.
- Abort: WAIT_CYCLES=3, write 0x40, drop `mem_req` after 1 cycle → no `mem_rdy`, and a later read of 0x40 returns its prior value.
- Reset mid-wait: assert `sys_rst` during WAIT of a write → `mem_rdy`, `busy`, `err` all 0 next cycle, and the write is not committed.
- Back-to-back, WAIT_CYCLES=0: hold `mem_req` high across three reads of 0x0, 0x4, 0x8 (address changed after each `mem_rdy`) → `mem_rdy` every second cycle with the correct data each time.
